trace_cmp_unit: RTL and testbench
=================================

Name: trace_cmp_unit

Overview:
- Synthesizable multi-lane commit-trace checker. Compares CPU writeback commits against a golden trace streamed in through a buffered valid/ready port.
- Successor to the single-lane, file-driven simulation checker. Supports LANES commits per cycle, a DEPTH-entry reference buffer, per-field error codes and end-PC detection.
- Sits beside the CPU writeback stage, in simulation or on FPGA. Fed by a trace loader (DMA or ROM reader).

Parameters:
LANES, 2, commit ports per cycle (1..4)
DEPTH, 8, reference FIFO entries (power of 2, >= LANES)
PC_W, 32, PC width
DATA_W, 32, writeback data width
END_PC, 32'hbfc00200, PC whose matched commit ends the test with pass

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
ref_valid  in  1  reference entry valid
ref_ready  out  1  FIFO can accept an entry
ref_pc  in  PC_W  reference PC
ref_wen  in  1  reference register write enable
ref_wnum  in  5  reference destination register
ref_wdata  in  DATA_W  reference write data
cmt_valid  in  LANES  per-lane commit valid; lane 0 is oldest
cmt_pc  in  LANES*PC_W  packed commit PCs; lane i at [i*PC_W +: PC_W]
cmt_wen  in  LANES  per-lane write enable
cmt_wnum  in  LANES*5  packed destination registers
cmt_wdata  in  LANES*DATA_W  packed write data
done  out  1  test finished, pass or error (sticky)
pass  out  1  END_PC committed with no error (sticky)
err  out  1  mismatch or protocol error (sticky)
err_code  out  6  latched error cause bits
err_pc  out  PC_W  commit PC of the failing lane
err_lane  out  2  index of the failing lane
commit_cnt  out  32  number of matched commits

Behaviour:
- Clock and reset: clk, with resetn synchronous active-low.
- Reset values: FIFO empty, state RUN. done, pass, err, err_code, err_pc, err_lane and commit_cnt are all 0. ref_ready is 1 in the first cycle after reset.
- States and transitions:
  - RUN -> ERR on any error.
  - RUN -> DONE on a matched END_PC commit.
  - ERR and DONE are absorbing until reset.
  - Reset asserted mid-operation discards FIFO contents and clears all outputs on the next edge.
- FIFO:
  - ref_ready = (count != DEPTH) && state==RUN. It depends only on registered count, not on same-cycle pops.
  - A push occurs on ref_valid && ref_ready.
  - Push and pop in the same cycle are legal; count updates by push - k.
  - Pointers wrap modulo DEPTH.
- Commit step (RUN only): k = number of valid lanes.
  - cmt_valid must be contiguous from lane 0. A gap (e.g. 2'b10) sets err_code[5], err_lane = first valid lane after the gap.
  - If count < k (underflow): err_code[4] (see Optional Feature).
  - Otherwise lane i is compared with FIFO entry head+i:
    - bit0: PC mismatch.
    - bit1: wen mismatch.
    - bit2: wnum mismatch, checked only when both wen = 1.
    - bit3: wdata mismatch, checked only when wen = 1 and wnum != 0 (writes to $0 carry no data).
  - The lowest mismatching lane is reported. Its bits go to err_code, its PC to err_pc.
  - On full match, k entries are popped and commit_cnt += k, saturating at 32'hFFFFFFFF.
- END_PC:
  - The first matched lane with pc==END_PC moves the state to DONE, with done = pass = 1.
  - Lanes above it in the same cycle are ignored: neither compared nor popped.
  - Entries up to and including the END_PC lane are popped and counted.
- Error handling: the entering-ERR cycle sets done = err = 1. No pops occur on error; the FIFO is frozen for debug.
- Latency: all outputs are registered and update on the edge after the offending or ending commit cycle.
- In DONE/ERR, commits and reference entries are ignored.

Optional Feature:
- Macro TRACE_CMP_STALL_EN.
- Defined:
  - Adds output port cmt_stall (1 bit) = state==RUN && count < LANES, driven from registered count.
  - A commit presented while count < k is not compared, popped or counted.
  - The CPU must hold cmt_* stable and re-present until count >= k.
  - err_code[4] is never set.
- Undefined: there is no cmt_stall port, and underflow is an error (err_code[4], ERR state).

Test Plan:
- Reset: hold resetn=0 for 3 cycles -> all outputs 0, ref_ready=1; push 8 entries -> ref_ready=0 after the 8th push.
- Dual match: push {bfc00000,wen1,r2,0x5},{bfc00004,wen0}; commit both in one cycle -> commit_cnt=2, err=0, count=0.
- Data mismatch in lane 1: ref wdata 0x5, commit 0x6 at pc bfc00004 -> next cycle err=1, done=1, err_code=6'h08, err_lane=1, err_pc=bfc00004, commit_cnt unchanged.
- $0 write: ref/commit wnum=0 with wdata 0x1 vs 0x2 -> no error, commit_cnt increments.
- End: lane 0 pc=bfc00200 matches while lane 1 is valid -> pass=1, done=1, commit_cnt +1, lane 1 ignored.
- Underflow: count=1, cmt_valid=2'b11 -> undefined macro: err_code=6'h10. Defined: cmt_stall=1, no error; push 1 entry and hold the commit -> both lanes match.

Source files
------------

// File: rtl/trace_cmp_unit.sv
// Multi-lane commit-trace checker: compares writeback commits against a buffered golden trace.
// Optional macro TRACE_CMP_STALL_EN adds cmt_stall and turns reference underflow into a stall.
module trace_cmp_unit #(
  parameter int              LANES  = 2,
  parameter int              DEPTH  = 8,
  parameter int              PC_W   = 32,
  parameter int              DATA_W = 32,
  parameter logic [PC_W-1:0] END_PC = 32'hbfc00200
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ref_valid,
  output logic                    ref_ready,
  input  logic [PC_W-1:0]         ref_pc,
  input  logic                    ref_wen,
  input  logic [4:0]              ref_wnum,
  input  logic [DATA_W-1:0]       ref_wdata,
  input  logic [LANES-1:0]        cmt_valid,
  input  logic [LANES*PC_W-1:0]   cmt_pc,
  input  logic [LANES-1:0]        cmt_wen,
  input  logic [LANES*5-1:0]      cmt_wnum,
  input  logic [LANES*DATA_W-1:0] cmt_wdata,
  output logic                    done,
  output logic                    pass,
  output logic                    err,
  output logic [5:0]              err_code,
  output logic [PC_W-1:0]         err_pc,
  output logic [1:0]              err_lane,
  output logic [31:0]             commit_cnt
`ifdef TRACE_CMP_STALL_EN
  ,
  output logic                    cmt_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

`ifdef TRACE_CMP_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic [PC_W-1:0]   pc_mem_q    [DEPTH];
  logic              wen_mem_q   [DEPTH];
  logic [4:0]        wnum_mem_q  [DEPTH];
  logic [DATA_W-1:0] wdata_mem_q [DEPTH];

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [5:0]    err_code_q, err_code_d;
  logic [PC_W-1:0] err_pc_q, err_pc_d;
  logic [1:0]    err_lane_q, err_lane_d;
  logic [31:0]   commit_cnt_q, commit_cnt_d;

  logic push;
  logic [CW-1:0] pop_n;
  logic [32:0]   cnt_sum;

  assign ref_ready = (count_q != CW'(DEPTH)) && (state_q == ST_RUN);
  assign push      = ref_valid && ref_ready;

  // Per-lane comparison against FIFO entry head+i; index wraps with AW-bit arithmetic.
  logic [PC_W-1:0] lane_pc   [LANES];
  logic [3:0]      lane_bits [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [AW-1:0]     idx;
    logic              c_wen;
    logic [4:0]        c_wnum;
    logic [DATA_W-1:0] c_wdata;
    logic              both_wen;
    assign idx        = head_q + AW'(g);
    assign lane_pc[g] = cmt_pc[g*PC_W +: PC_W];
    assign c_wen      = cmt_wen[g];
    assign c_wnum     = cmt_wnum[g*5 +: 5];
    assign c_wdata    = cmt_wdata[g*DATA_W +: DATA_W];
    assign both_wen   = c_wen && wen_mem_q[idx];
    assign lane_bits[g] = {
      both_wen && (wnum_mem_q[idx] != 5'd0) && (c_wdata != wdata_mem_q[idx]),
      both_wen && (c_wnum != wnum_mem_q[idx]),
      c_wen != wen_mem_q[idx],
      lane_pc[g] != pc_mem_q[idx]
    };
  end

  logic [CW-1:0]   k, match_n;
  logic            seen_hole, gap, mis_found, end_found;
  logic [1:0]      gap_lane, mis_lane;
  logic [PC_W-1:0] gap_pc, mis_pc;
  logic [3:0]      mis_bits;

  // Scan lanes oldest-first; stop at the first mismatch or the first matched END_PC.
  always_comb begin
    k         = '0;
    match_n   = '0;
    seen_hole = 1'b0;
    gap       = 1'b0;
    gap_lane  = '0;
    gap_pc    = lane_pc[0];
    mis_found = 1'b0;
    end_found = 1'b0;
    mis_bits  = '0;
    mis_lane  = '0;
    mis_pc    = lane_pc[0];
    for (int i = 0; i < LANES; i++) begin
      if (!cmt_valid[i]) begin
        seen_hole = 1'b1;
      end else begin
        k = k + CW'(1);
        if (seen_hole && !gap) begin
          gap      = 1'b1;
          gap_lane = 2'(i);
          gap_pc   = lane_pc[i];
        end
        if (!mis_found && !end_found) begin
          if (lane_bits[i] != 4'd0) begin
            mis_found = 1'b1;
            mis_bits  = lane_bits[i];
            mis_lane  = 2'(i);
            mis_pc    = lane_pc[i];
          end else begin
            match_n   = match_n + CW'(1);
            end_found = (lane_pc[i] == END_PC);
          end
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    err_pc_d   = err_pc_q;
    err_lane_d = err_lane_q;
    pop_n      = '0;
    if (state_q == ST_RUN && cmt_valid != '0) begin
      if (gap) begin
        state_d    = ST_ERR;
        err_code_d = 6'h20;
        err_lane_d = gap_lane;
        err_pc_d   = gap_pc;
      end else if (count_q < k) begin
        // With stalling enabled the commit is simply held off until the trace catches up.
        if (!STALL_EN) begin
          state_d    = ST_ERR;
          err_code_d = 6'h10;
          err_lane_d = 2'd0;
          err_pc_d   = lane_pc[0];
        end
      end else if (mis_found) begin
        state_d    = ST_ERR;
        err_code_d = {2'b00, mis_bits};
        err_lane_d = mis_lane;
        err_pc_d   = mis_pc;
      end else begin
        pop_n = match_n;
        if (end_found) state_d = ST_DONE;
      end
    end
  end

  assign cnt_sum      = {1'b0, commit_cnt_q} + 33'(pop_n);
  assign commit_cnt_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
  assign head_d       = head_q + AW'(pop_n);
  assign tail_d       = push ? tail_q + AW'(1) : tail_q;
  assign count_d      = count_q + CW'(push) - pop_n;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      state_q      <= ST_RUN;
      err_code_q   <= '0;
      err_pc_q     <= '0;
      err_lane_q   <= '0;
      commit_cnt_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      state_q      <= state_d;
      err_code_q   <= err_code_d;
      err_pc_q     <= err_pc_d;
      err_lane_q   <= err_lane_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]    <= ref_pc;
      wen_mem_q[tail_q]   <= ref_wen;
      wnum_mem_q[tail_q]  <= ref_wnum;
      wdata_mem_q[tail_q] <= ref_wdata;
    end
  end

  assign done       = (state_q != ST_RUN);
  assign pass       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);
  assign err_code   = err_code_q;
  assign err_pc     = err_pc_q;
  assign err_lane   = err_lane_q;
  assign commit_cnt = commit_cnt_q;

`ifdef TRACE_CMP_STALL_EN
  assign cmt_stall = (state_q == ST_RUN) && (count_q < CW'(LANES));
`endif

endmodule

// File: tb/tb_trace_cmp_unit.sv
// Scoreboard bench for trace_cmp_unit (LANES=2, DEPTH=8); covers both TRACE_CMP_STALL_EN builds.
module tb_trace_cmp_unit;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ref_valid = 1'b0;
  logic        ref_ready;
  logic [31:0] ref_pc = '0;
  logic        ref_wen = 1'b0;
  logic [4:0]  ref_wnum = '0;
  logic [31:0] ref_wdata = '0;
  logic [1:0]  cmt_valid = '0;
  logic [63:0] cmt_pc = '0;
  logic [1:0]  cmt_wen = '0;
  logic [9:0]  cmt_wnum = '0;
  logic [63:0] cmt_wdata = '0;
  logic        done, pass, err;
  logic [5:0]  err_code;
  logic [31:0] err_pc;
  logic [1:0]  err_lane;
  logic [31:0] commit_cnt;
`ifdef TRACE_CMP_STALL_EN
  logic        cmt_stall;
`endif

  int checks = 0;
  int errors = 0;

  trace_cmp_unit dut (
    .clk(clk), .resetn(resetn),
    .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_pc(ref_pc),
    .ref_wen(ref_wen), .ref_wnum(ref_wnum), .ref_wdata(ref_wdata),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_wen(cmt_wen),
    .cmt_wnum(cmt_wnum), .cmt_wdata(cmt_wdata),
    .done(done), .pass(pass), .err(err), .err_code(err_code),
    .err_pc(err_pc), .err_lane(err_lane), .commit_cnt(commit_cnt)
`ifdef TRACE_CMP_STALL_EN
    , .cmt_stall(cmt_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cnt;
    logic        done;
    logic        pass;
    logic        err;
    logic [5:0]  code;
    logic [31:0] pc;
    logic [1:0]  lane;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(input logic [31:0] cnt, input logic d, input logic p,
                              input logic e, input logic [5:0] code,
                              input logic [31:0] pc, input logic [1:0] lane);
    exp_t r;
    r.cnt = cnt; r.done = d; r.pass = p; r.err = e; r.code = code; r.pc = pc; r.lane = lane;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: any cycle that presented a commit produces a visible response one edge later.
  initial begin
    exp_t act, e;
    logic seen;
    forever begin
      @(posedge clk);
      seen = resetn && (cmt_valid != 2'b00);
      @(negedge clk);
      if (seen) begin
        act = mk(commit_cnt, done, pass, err, err_code, err_pc, err_lane);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: got response %0h with no expectation", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL commit_resp: got cnt=%0h done=%0b pass=%0b err=%0b code=%0h pc=%0h lane=%0d expected cnt=%0h done=%0b pass=%0b err=%0b code=%0h pc=%0h lane=%0d",
                     act.cnt, act.done, act.pass, act.err, act.code, act.pc, act.lane,
                     e.cnt, e.done, e.pass, e.err, e.code, e.pc, e.lane);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; ref_valid = 1'b0; cmt_valid = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic push(input logic [31:0] pc, input logic w, input logic [4:0] n, input logic [31:0] d);
    ref_pc = pc; ref_wen = w; ref_wnum = n; ref_wdata = d; ref_valid = 1'b1;
    @(negedge clk);
    ref_valid = 1'b0;
  endtask

  task automatic commit(input logic [1:0] v,
                        input logic [31:0] p0, input logic w0, input logic [4:0] n0, input logic [31:0] d0,
                        input logic [31:0] p1, input logic w1, input logic [4:0] n1, input logic [31:0] d1,
                        input exp_t e);
    cmt_valid = v; cmt_pc = {p1, p0}; cmt_wen = {w1, w0};
    cmt_wnum = {n1, n0}; cmt_wdata = {d1, d0};
    exp_q.push_back(e);
    @(negedge clk);
    cmt_valid = '0;
  endtask

  initial begin
    // Reset state and fill to full
    do_reset();
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_code", 64'(err_code), 64'd0);
    chk("rst_pc_lane", {err_pc, 30'd0, err_lane}, 64'd0);
    chk("rst_cnt", 64'(commit_cnt), 64'd0);
    chk("rst_ref_ready", 64'(ref_ready), 64'd1);
`ifdef TRACE_CMP_STALL_EN
    chk("rst_stall", 64'(cmt_stall), 64'd1);
`endif
    push(32'hbfc00000, 1'b1, 5'd2, 32'h5);
    push(32'hbfc00004, 1'b0, 5'd0, 32'h0);
    push(32'hbfc00008, 1'b1, 5'd0, 32'h1);
    push(32'hbfc0000c, 1'b1, 5'd3, 32'h7);
    push(32'hbfc00010, 1'b0, 5'd0, 32'h0);
    push(32'hbfc00014, 1'b1, 5'd4, 32'h9);
    push(32'hbfc00200, 1'b0, 5'd0, 32'h0);
    chk("ready_before_full", 64'(ref_ready), 64'd1);
    push(32'hbfc00204, 1'b1, 5'd5, 32'h3);
    chk("ready_full", 64'(ref_ready), 64'd0);
`ifdef TRACE_CMP_STALL_EN
    chk("stall_full", 64'(cmt_stall), 64'd0);
`endif
    // Dual match
    commit(2'b11, 32'hbfc00000, 1'b1, 5'd2, 32'h5, 32'hbfc00004, 1'b0, 5'd0, 32'h0,
           mk(32'd2, 0, 0, 0, 6'h00, 32'h0, 2'd0));
    chk("ready_after_pop", 64'(ref_ready), 64'd1);
    // $0 write: data differs but is not compared
    commit(2'b01, 32'hbfc00008, 1'b1, 5'd0, 32'h2, 32'hdead0000, 1'b1, 5'd9, 32'h9,
           mk(32'd3, 0, 0, 0, 6'h00, 32'h0, 2'd0));
    commit(2'b11, 32'hbfc0000c, 1'b1, 5'd3, 32'h7, 32'hbfc00010, 1'b0, 5'd0, 32'h0,
           mk(32'd5, 0, 0, 0, 6'h00, 32'h0, 2'd0));
    commit(2'b01, 32'hbfc00014, 1'b1, 5'd4, 32'h9, 32'h0, 1'b0, 5'd0, 32'h0,
           mk(32'd6, 0, 0, 0, 6'h00, 32'h0, 2'd0));
    // END_PC in lane 0; lane 1 carries garbage and must be ignored
    commit(2'b11, 32'hbfc00200, 1'b0, 5'd0, 32'h0, 32'h12345678, 1'b1, 5'd7, 32'h55,
           mk(32'd7, 1, 1, 0, 6'h00, 32'h0, 2'd0));
    chk("ready_done", 64'(ref_ready), 64'd0);

    // Data mismatch in lane 1
    do_reset();
    push(32'hbfc00000, 1'b1, 5'd2, 32'h5);
    push(32'hbfc00004, 1'b1, 5'd3, 32'h5);
    commit(2'b11, 32'hbfc00000, 1'b1, 5'd2, 32'h5, 32'hbfc00004, 1'b1, 5'd3, 32'h6,
           mk(32'd0, 1, 0, 1, 6'h08, 32'hbfc00004, 2'd1));
    chk("ready_err", 64'(ref_ready), 64'd0);

    // Non-contiguous valid
    do_reset();
    push(32'hbfc00000, 1'b0, 5'd0, 32'h0);
    push(32'hbfc00004, 1'b0, 5'd0, 32'h0);
    commit(2'b10, 32'h0, 1'b0, 5'd0, 32'h0, 32'hbfc00004, 1'b0, 5'd0, 32'h0,
           mk(32'd0, 1, 0, 1, 6'h20, 32'hbfc00004, 2'd1));

    // wen mismatch alone (wnum/wdata not checked when only one side writes)
    do_reset();
    push(32'hbfc00000, 1'b1, 5'd2, 32'h5);
    push(32'hbfc00004, 1'b0, 5'd0, 32'h0);
    commit(2'b01, 32'hbfc00000, 1'b1, 5'd2, 32'h5, 32'h0, 1'b0, 5'd0, 32'h0,
           mk(32'd1, 0, 0, 0, 6'h00, 32'h0, 2'd0));
    commit(2'b01, 32'hbfc00004, 1'b1, 5'd7, 32'h9, 32'h0, 1'b0, 5'd0, 32'h0,
           mk(32'd1, 1, 0, 1, 6'h02, 32'hbfc00004, 2'd0));

    // PC mismatch plus wnum mismatch in lane 0
    do_reset();
    push(32'hbfc00000, 1'b1, 5'd2, 32'h5);
    commit(2'b01, 32'hbfc00040, 1'b1, 5'd6, 32'h5, 32'h0, 1'b0, 5'd0, 32'h0,
           mk(32'd0, 1, 0, 1, 6'h05, 32'hbfc00040, 2'd0));

    // Underflow: one entry, two commits
    do_reset();
    push(32'hbfc00000, 1'b1, 5'd2, 32'h5);
`ifdef TRACE_CMP_STALL_EN
    chk("stall_underflow", 64'(cmt_stall), 64'd1);
    commit(2'b11, 32'hbfc00000, 1'b1, 5'd2, 32'h5, 32'hbfc00004, 1'b0, 5'd0, 32'h0,
           mk(32'd0, 0, 0, 0, 6'h00, 32'h0, 2'd0));
    ref_pc = 32'hbfc00004; ref_wen = 1'b0; ref_wnum = 5'd0; ref_wdata = 32'h0; ref_valid = 1'b1;
    commit(2'b11, 32'hbfc00000, 1'b1, 5'd2, 32'h5, 32'hbfc00004, 1'b0, 5'd0, 32'h0,
           mk(32'd0, 0, 0, 0, 6'h00, 32'h0, 2'd0));
    ref_valid = 1'b0;
    chk("stall_released", 64'(cmt_stall), 64'd0);
    commit(2'b11, 32'hbfc00000, 1'b1, 5'd2, 32'h5, 32'hbfc00004, 1'b0, 5'd0, 32'h0,
           mk(32'd2, 0, 0, 0, 6'h00, 32'h0, 2'd0));
`else
    commit(2'b11, 32'hbfc00000, 1'b1, 5'd2, 32'h5, 32'hbfc00004, 1'b0, 5'd0, 32'h0,
           mk(32'd0, 1, 0, 1, 6'h10, 32'hbfc00000, 2'd0));
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
